// File: rtl/wb_select_unit.sv
// Registered writeback selector: picks ALU result, link address or aligned load
// data for the register-file write port, waiting on memory with a timeout.
module wb_select_unit #(
  parameter int XLEN         = 32,
  parameter int RA_W         = 5,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            wb_ready,
  input  logic [1:0]      reg_sel,
  input  logic [RA_W-1:0] rd_addr,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] aluout,
  input  logic [XLEN-1:0] inf_out,
  input  logic            mem_rvalid,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RA_W-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              rf_we_q, rf_we_d;
  logic              load_err_q, load_err_d;
  logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_val;
  logic              ld_ok;

  assign wb_ready = rst_n && (state_q == IDLE);
  assign rf_we    = rf_we_q;
  assign load_err = load_err_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Sub-word lanes come from the low 32-bit word of the memory bus.
  always_comb begin
    ld_byte = inf_out[{ld_off_q, 3'b000} +: 8];
    ld_half = inf_out[{ld_off_q[1], 4'b0000} +: 16];
    ld_val  = '0;
    ld_ok   = 1'b0;
    case (ld_f3_q)
      3'b000: begin ld_val = XLEN'($signed(ld_byte));         ld_ok = 1'b1;               end
      3'b001: begin ld_val = XLEN'($signed(ld_half));         ld_ok = !ld_off_q[0];       end
      3'b010: begin ld_val = XLEN'($signed(inf_out[31:0]));   ld_ok = (ld_off_q == 2'b00); end
      3'b100: begin ld_val = XLEN'(ld_byte);                  ld_ok = 1'b1;               end
      3'b101: begin ld_val = XLEN'(ld_half);                  ld_ok = !ld_off_q[0];       end
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    rf_we_d    = 1'b0;
    load_err_d = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (state_q)
      IDLE: begin
        if (issue_valid && wb_ready) begin
          if (reg_sel == 2'b01) begin
            ld_rd_d  = rd_addr;
            ld_f3_d  = funct3;
            ld_off_d = byte_off;
            cnt_d    = '0;
            state_d  = WAIT_MEM;
          end else begin
            rf_waddr_d = rd_addr;
            rf_wdata_d = (reg_sel == 2'b11) ? pc + XLEN'(4) : aluout;
            rf_we_d    = |rd_addr;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (ld_ok) begin
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = ld_val;
            rf_we_d    = |ld_rd_q;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(LOAD_TIMEOUT - 1)) begin
          // This idle cycle is the LOAD_TIMEOUT-th one: abort.
          cnt_d      = CNT_W'(LOAD_TIMEOUT);
          load_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      rf_we_q    <= 1'b0;
      load_err_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      rf_we_q    <= rf_we_d;
      load_err_q <= load_err_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed bench for wb_select_unit: ALU/link writes, sub-word loads,
// misalignment, timeout and reset during a pending load.
module tb_wb_select_unit;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic            wb_ready;
  logic [1:0]      reg_sel;
  logic [RA_W-1:0] rd_addr;
  logic [2:0]      funct3;
  logic [1:0]      byte_off;
  logic [XLEN-1:0] pc, aluout, inf_out;
  logic            mem_rvalid;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            load_err;

  int n_chk  = 0;
  int n_fail = 0;

  wb_select_unit #(.XLEN(XLEN), .RA_W(RA_W), .LOAD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .wb_ready(wb_ready),
    .reg_sel(reg_sel), .rd_addr(rd_addr), .funct3(funct3), .byte_off(byte_off),
    .pc(pc), .aluout(aluout), .inf_out(inf_out), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue a load to rd=9, hold off mem_rvalid so it is sampled 'delay' edges
  // after the accept edge, then check the result cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] data, input int delay,
                         input logic exp_err, input logic [31:0] exp_data);
    @(negedge clk);
    issue_valid = 1'b1; reg_sel = 2'b01; rd_addr = 5'd9;
    funct3 = f3; byte_off = off; inf_out = data; mem_rvalid = 1'b0;
    @(negedge clk);
    issue_valid = 1'b0; reg_sel = 2'b00;
    for (int i = 0; i < delay; i++) begin
      chk({tag, "_busy"}, wb_ready, 1'b0);
      if (i == delay - 1) mem_rvalid = 1'b1;
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    chk({tag, "_err"}, load_err, exp_err);
    chk({tag, "_we"},  rf_we, !exp_err);
    chk({tag, "_rdy"}, wb_ready, 1'b1);
    if (!exp_err) begin
      chk({tag, "_data"}, rf_wdata, exp_data);
      chk({tag, "_addr"}, rf_waddr, 5'd9);
    end
  endtask

  initial begin
    rst_n = 1'b1; issue_valid = 1'b0; reg_sel = 2'b00; rd_addr = '0;
    funct3 = '0; byte_off = '0; pc = '0; aluout = '0; inf_out = '0; mem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", wb_ready, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_err", load_err, 1'b0);
    chk("rst_data", rf_wdata, 32'h0);
    chk("rst_addr", rf_waddr, 5'd0);
    rst_n = 1'b1;
    #1 chk("rdy_after_rst", wb_ready, 1'b1);

    // ALU back-to-back
    @(negedge clk);
    issue_valid = 1'b1; reg_sel = 2'b00; rd_addr = 5'd5; aluout = 32'h0000_1234;
    @(negedge clk);
    chk("alu1_we", rf_we, 1'b1);
    chk("alu1_addr", rf_waddr, 5'd5);
    chk("alu1_data", rf_wdata, 32'h0000_1234);
    reg_sel = 2'b10; rd_addr = 5'd7; aluout = 32'hA5A5_0001;
    @(negedge clk);
    chk("alu2_we", rf_we, 1'b1);
    chk("alu2_addr", rf_waddr, 5'd7);
    chk("alu2_data", rf_wdata, 32'hA5A5_0001);
    issue_valid = 1'b0;
    @(negedge clk);
    chk("idle_we", rf_we, 1'b0);
    chk("hold_data", rf_wdata, 32'hA5A5_0001);

    // link with wrap, then rd=0
    issue_valid = 1'b1; reg_sel = 2'b11; rd_addr = 5'd1; pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("link_we", rf_we, 1'b1);
    chk("link_data", rf_wdata, 32'h0);
    rd_addr = 5'd0; pc = 32'h0000_1000;
    @(negedge clk);
    chk("link_x0_we", rf_we, 1'b0);
    issue_valid = 1'b0;

    do_load("lb",   3'b000, 2'd2, 32'h0080_0000, 3, 1'b0, 32'hFFFF_FF80);
    do_load("lbu",  3'b100, 2'd2, 32'h0080_0000, 3, 1'b0, 32'h0000_0080);
    do_load("lhu",  3'b101, 2'd2, 32'hBEEF_0000, 1, 1'b0, 32'h0000_BEEF);
    do_load("lh",   3'b001, 2'd0, 32'h1234_8001, 2, 1'b0, 32'hFFFF_8001);
    do_load("lw",   3'b010, 2'd0, 32'h1234_5678, 1, 1'b0, 32'h1234_5678);
    do_load("lh_mis", 3'b001, 2'd1, 32'hBEEF_0000, 1, 1'b1, 32'h0);
    do_load("lw_mis", 3'b010, 2'd2, 32'hBEEF_0000, 2, 1'b1, 32'h0);
    do_load("f3_bad", 3'b011, 2'd0, 32'hBEEF_0000, 1, 1'b1, 32'h0);

    // timeout: load_err TO cycles after the accept edge
    @(negedge clk);
    issue_valid = 1'b1; reg_sel = 2'b01; rd_addr = 5'd4; funct3 = 3'b010; byte_off = 2'd0;
    inf_out = 32'hDEAD_BEEF; mem_rvalid = 1'b0;
    @(negedge clk);
    issue_valid = 1'b0; reg_sel = 2'b00;
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      chk("to_wait_err", load_err, 1'b0);
      chk("to_wait_rdy", wb_ready, 1'b0);
    end
    @(negedge clk);
    chk("to_err", load_err, 1'b1);
    chk("to_we", rf_we, 1'b0);
    chk("to_rdy", wb_ready, 1'b1);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_we", rf_we, 1'b0);
    chk("late_err", load_err, 1'b0);

    // reset while waiting on memory
    do_load("pre_rst", 3'b010, 2'd0, 32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D);
    @(negedge clk);
    issue_valid = 1'b1; reg_sel = 2'b01; rd_addr = 5'd6; funct3 = 3'b010; byte_off = 2'd0;
    @(negedge clk);
    issue_valid = 1'b0; reg_sel = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", wb_ready, 1'b0);
    chk("mid_rst_we", rf_we, 1'b0);
    chk("mid_rst_err", load_err, 1'b0);
    chk("mid_rst_data", rf_wdata, 32'h0);
    chk("mid_rst_addr", rf_waddr, 5'd0);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
    issue_valid = 1'b1; reg_sel = 2'b00; rd_addr = 5'd3; aluout = 32'h0000_0055;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("post_rst_we", rf_we, 1'b1);
    chk("post_rst_addr", rf_waddr, 5'd3);
    chk("post_rst_data", rf_wdata, 32'h0000_0055);
    chk("post_rst_err", load_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // rf_we and load_err must never coincide
  always @(negedge clk) begin
    if (rst_n && rf_we && load_err) begin
      n_fail++;
      $display("FAIL excl: rf_we=%0b load_err=%0b required not both 1", rf_we, load_err);
    end
  end

endmodule

// File: doc/wb_select_unit.md
# wb_select_unit

Registered writeback selector for the RISC-V core. It takes over the combinational register-select mux and sits between execute/memory and the register-file write port. It chooses the destination value: ALU result, load data or link address (pc+4). It waits a variable number of cycles for load data, aligns and sign/zero-extends sub-word loads, and flags load timeouts and misalignment. The block is parametrised in data width, register-address width and timeout.

## Interface
- XLEN, 32, datapath width in bits (multiple of 32).
- RA_W, 5, register address width.
- LOAD_TIMEOUT, 15, max cycles spent in WAIT_MEM before abort (≥1).

Clock and reset are fixed: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  writeback request present this cycle.
- wb_ready  out  1  block can accept an issue; 1 only in IDLE with rst_n high.
- reg_sel  in  2  00/10 = ALU, 01 = load, 11 = link.
- rd_addr  in  RA_W  destination register.
- funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- byte_off  in  2  load address bits [1:0].
- pc  in  XLEN  PC of the issuing instruction.
- aluout  in  XLEN  ALU result.
- inf_out  in  XLEN  memory read word.
- mem_rvalid  in  1  inf_out valid this cycle.
- rf_we  out  1  register-file write strobe, one-cycle pulse.
- rf_waddr  out  RA_W  write address.
- rf_wdata  out  XLEN  write data.
- load_err  out  1  one-cycle pulse on load timeout or misalignment.

## Operation
- FSM states are IDLE and WAIT_MEM. An issue is accepted on a rising edge where issue_valid and wb_ready are both 1.
- IDLE, reg_sel ≠ 01:
  - rf_wdata ← aluout for 00/10, or pc+4 (mod 2^XLEN) for 11.
  - rf_waddr ← rd_addr.
  - rf_we ← (rd_addr ≠ 0).
  - State stays IDLE, so back-to-back issues are accepted every cycle.
- IDLE, reg_sel = 01:
  - Latch rd_addr, funct3 and byte_off.
  - Clear the timeout counter and go to WAIT_MEM.
- WAIT_MEM:
  - wb_ready = 0. mem_rvalid is sampled only in this state; a mem_rvalid coinciding with the accept edge is ignored.
  - On mem_rvalid, extract from inf_out:
    - lb/lbu: byte inf_out[8·off+7:8·off].
    - lh/lhu: half inf_out[16·off[1]+15:16·off[1]]. Legal only if off[0] = 0.
    - lw: whole word. Legal only if off = 0.
  - lb/lh sign-extend to XLEN; lbu/lhu zero-extend.
  - Legal load: register rf_wdata/rf_waddr; rf_we ← (rd_addr ≠ 0); return to IDLE.
  - Misaligned offset or undefined funct3 (011, 110, 111): load_err = 1, rf_we = 0, return to IDLE.
  - Counter increments each cycle without mem_rvalid. When it reaches LOAD_TIMEOUT: load_err = 1, rf_we = 0, return to IDLE. Data arriving later is ignored.
- rf_waddr/rf_wdata hold their last value between pulses.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, counter 0, rf_we 0, rf_waddr 0, rf_wdata 0, load_err 0, wb_ready 0. wb_ready rises once rst_n is high.
- Non-load latency: 1 cycle; rf_we is high in the cycle after the accept edge.
- Load latency: rf_we or load_err is high in the cycle after the edge that samples mem_rvalid or hits timeout. wb_ready returns to 1 in that same cycle.
- rf_we and load_err are never both 1 in one cycle.
- Reset during WAIT_MEM aborts the load: no write, no load_err.

## Test plan
- Reset, then ALU issue with aluout=0x0000_1234, rd=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234. A second issue on the following cycle gives a write on the next cycle.
- Link issue with pc=0xFFFF_FFFC, rd=1 -> rf_wdata=0x0000_0000 (wrap). Same issue with rd=0 -> rf_we stays 0.
- Load lb, off=2, inf_out=0x0080_0000, mem_rvalid 3 cycles after accept -> wb_ready=0 for 3 cycles, then rf_wdata=0xFFFF_FF80. With lbu the result is 0x0000_0080.
- lhu off=2, inf_out=0xBEEF_0000 -> 0x0000_BEEF. lh off=1 or lw off=2 -> load_err pulse, no rf_we.
- Load with mem_rvalid never asserted -> load_err exactly LOAD_TIMEOUT cycles after entering WAIT_MEM, wb_ready back to 1. A late mem_rvalid produces no write.
- rst_n dropped mid-WAIT_MEM -> all outputs 0 immediately. After release the first ALU issue writes normally.
